dac_spi_monitor: RTL

- Receive-side decoder for the AD5662 3-wire SPI stream that the DAC output block drives on DAC_SYNC, DAC_SCLK and DAC_DIN.
- Oversamples the three lines in the dataclk domain and reassembles each 24-bit frame into the 2 power-down bits and the 16-bit DAC code.
- Flags malformed frames and counts good and bad frames.
- Sits on the debug path beside each DAC channel, so host readback can compare the transmitted code with the intended DAC_register value.

---
 rtl/dac_spi_monitor.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dac_spi_monitor.sv
// Receive-side decoder for the AD5662 3-wire DAC SPI stream: rebuilds each frame, flags malformed ones, counts both.
// Define DAC_MON_SYNC_EN to put a 2-flop synchronizer on DAC_SYNC/DAC_SCLK/DAC_DIN (latency 3 instead of 1).
module dac_spi_monitor #(
  parameter int unsigned FRAME_BITS = 24,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                 dataclk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 DAC_SYNC,
  input  logic                 DAC_SCLK,
  input  logic                 DAC_DIN,
  output logic [15:0]          rx_data,
  output logic [1:0]           rx_pd,
  output logic                 rx_valid,
  output logic                 rx_error,
  output logic                 rx_err_long,
  output logic                 busy,
  output logic [15:0]          frame_count,
  output logic [ERR_CNT_W-1:0] error_count
);

  localparam int unsigned CNT_W = 5;
  // Only frame bits 17:0 are ever used, so older bits are simply shifted out
  localparam int unsigned SR_W  = 18;
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic {IDLE, SHIFT} state_t;

  logic sync_c, sclk_c, din_c, vld_c;

`ifdef DAC_MON_SYNC_EN
  logic [1:0] sync_ff, sclk_ff, din_ff, vld_ff;

  // Two-flop synchronizers; vld_ff marks when the pipe holds real pin samples
  always_ff @(posedge dataclk or negedge reset_n) begin
    if (!reset_n) begin
      sync_ff <= 2'b11;
      sclk_ff <= 2'b00;
      din_ff  <= 2'b00;
      vld_ff  <= 2'b00;
    end else begin
      sync_ff <= {sync_ff[0], DAC_SYNC};
      sclk_ff <= {sclk_ff[0], DAC_SCLK};
      din_ff  <= {din_ff[0], DAC_DIN};
      vld_ff  <= {vld_ff[0], 1'b1};
    end
  end

  assign sync_c = sync_ff[1];
  assign sclk_c = sclk_ff[1];
  assign din_c  = din_ff[1];
  assign vld_c  = vld_ff[1];
`else
  assign sync_c = DAC_SYNC;
  assign sclk_c = DAC_SCLK;
  assign din_c  = DAC_DIN;
  assign vld_c  = 1'b1;
`endif

  logic sync_d, sclk_d, sync_armed;
  logic sync_fall_c, sync_rise_c, sclk_fall_c;

  // A fall only counts once SYNC has really been seen high since reset,
  // so a release with SYNC already low does not start a frame
  always_ff @(posedge dataclk or negedge reset_n) begin
    if (!reset_n) begin
      sync_d     <= 1'b1;
      sclk_d     <= 1'b0;
      sync_armed <= 1'b0;
    end else begin
      sync_d     <= sync_c;
      sclk_d     <= sclk_c;
      sync_armed <= sync_armed | (vld_c & sync_c);
    end
  end

  assign sync_fall_c = sync_armed & sync_d & ~sync_c;
  assign sync_rise_c = ~sync_d & sync_c;
  assign sclk_fall_c = sclk_d & ~sclk_c;

  state_t           state;
  logic [SR_W-1:0]  sr;
  logic [CNT_W-1:0] cnt;

  // Frame capture FSM with registered results
  always_ff @(posedge dataclk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      sr          <= '0;
      cnt         <= '0;
      rx_data     <= '0;
      rx_pd       <= '0;
      rx_valid    <= 1'b0;
      rx_error    <= 1'b0;
      rx_err_long <= 1'b0;
      busy        <= 1'b0;
      frame_count <= '0;
      error_count <= '0;
    end else begin
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      case (state)
        IDLE: begin
          if (sync_fall_c && enable) begin
            state <= SHIFT;
            busy  <= 1'b1;
            sr    <= '0;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          if (sync_rise_c) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (cnt == FRAME_CNT) begin
              rx_data     <= sr[15:0];
              rx_pd       <= sr[17:16];
              rx_valid    <= 1'b1;
              frame_count <= frame_count + 16'd1;
            end else begin
              rx_error    <= 1'b1;
              rx_err_long <= (cnt > FRAME_CNT);
              if (error_count != '1) error_count <= error_count + ERR_CNT_W'(1);
            end
          end else if (sclk_fall_c) begin
            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
            if (cnt < FRAME_CNT) sr <= {sr[SR_W-2:0], din_c};
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
